tx_frame_feeder: RTL and testbench

TX_FRAME_FEEDER -- requirements
Module: tx_frame_feeder

---
 rtl/tx_frame_feeder.sv | 170 +++++++++++++++++
 tb/tb_tx_frame_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_feeder.sv
// tx_frame_feeder: byte FIFO feeding a UART 8N1 transmitter with an optional
// idle-high gap after each stop bit. Frames are started only while en is high;
// a running frame always completes unless reset is asserted.
module tx_frame_feeder #(
  parameter int CLKS_PER_BIT = 1_000_000/115_200,
  parameter int FIFO_DEPTH   = 16,
  parameter int GAP_BITS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, can_pop, baud_end, fin;
  logic [BW-1:0]   baud_cnt, baud_n;
  logic [2:0]      bit_idx, bit_n;
  logic [GW-1:0]   gap_idx, gap_n;
  logic [7:0]      shreg, shreg_n;
  logic            ser_n, busy_n;
  logic [15:0]     fcnt_n;

  assign s_ready  = (fifo_count != FULL);
  assign push     = s_valid && s_ready;
  assign can_pop  = en && (fifo_count != '0);
  assign baud_end = (baud_cnt == BAUD_LAST);

  // FIFO storage; contents are dropped on reset by clearing the pointers/count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; push+pop together leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmitter state, bit timing and registered line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      gap_idx    <= '0;
      shreg      <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      gap_idx    <= gap_n;
      shreg      <= shreg_n;
      serial_out <= ser_n;
      busy       <= busy_n;
      frame_cnt  <= fcnt_n;
    end
  end

  // Next-state logic; a frame end pops the next byte in the same cycle so
  // back-to-back frames leave no dead cycle
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    gap_n   = gap_idx;
    shreg_n = shreg;
    ser_n   = serial_out;
    busy_n  = busy;
    fcnt_n  = frame_cnt;
    pop     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: ;
      START: begin
        if (baud_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          ser_n   = shreg[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            ser_n   = 1'b1;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shreg_n = shreg >> 1;
            ser_n   = shreg[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (GAP_BITS == 0) begin
            fin = 1'b1;
          end else begin
            state_n = GAP;
            gap_n   = '0;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      GAP: begin
        if (baud_end) begin
          baud_n = '0;
          if (gap_idx == GAP_LAST) fin = 1'b1;
          else                     gap_n = gap_idx + 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (fin) fcnt_n = frame_cnt + 1'b1;

    if ((state == IDLE || fin) && can_pop) begin
      pop     = 1'b1;
      state_n = START;
      baud_n  = '0;
      shreg_n = mem[rd_ptr];
      ser_n   = 1'b0;
      busy_n  = 1'b1;
    end else if (fin) begin
      state_n = IDLE;
      ser_n   = 1'b1;
      busy_n  = 1'b0;
    end
  end
endmodule

// File: tb/tb_tx_frame_feeder.sv
// Bench for tx_frame_feeder: a line monitor decodes frames into rx_q, bytes
// expected on the line are queued in exp_q as they are driven, and each
// scenario task compares the two plus its own timing/status observations.
module tb_tx_frame_feeder;
  localparam int CPB = 8;
  localparam int FL  = 11 * CPB;   // frame period with one gap bit

  logic        clk = 1'b0, rst = 1'b1;
  logic        en = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, serial_out, busy;
  logic [4:0]  fifo_count;
  logic [15:0] frame_cnt;

  logic        en_g0 = 1'b0, s_valid_g0 = 1'b0;
  logic [7:0]  s_data_g0 = 8'h00;
  logic        s_ready_g0, serial_out_g0, busy_g0;
  logic [4:0]  fifo_count_g0;
  logic [15:0] frame_cnt_g0;

  int n_checks = 0, n_fail = 0, cyc = 0, exp_fc = 0;

  typedef struct { logic [7:0] d; logic stop_ok; int t; } rx_t;
  logic [7:0] exp_q[$];
  rx_t        rx_q[$];

  tx_frame_feeder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .GAP_BITS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .serial_out(serial_out), .busy(busy),
    .fifo_count(fifo_count), .frame_cnt(frame_cnt));

  tx_frame_feeder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .GAP_BITS(0)) dut_g0 (
    .clk(clk), .rst(rst), .en(en_g0), .s_data(s_data_g0), .s_valid(s_valid_g0),
    .s_ready(s_ready_g0), .serial_out(serial_out_g0), .busy(busy_g0),
    .fifo_count(fifo_count_g0), .frame_cnt(frame_cnt_g0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line level at offset k from the start-bit falling edge
  function automatic logic exp_level(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // UART decoder: samples mid-bit, drops frames cut by reset
  initial begin : monitor
    rx_t r;
    logic [7:0] b;
    logic ok, st;
    forever begin
      @(negedge clk);
      if (!rst && serial_out === 1'b0) begin
        r.t = cyc; ok = 1'b1; st = 1'b0; b = 8'h00;
        for (int k = 1; k < 10*CPB; k++) begin
          @(negedge clk);
          if (rst) begin ok = 1'b0; break; end
          if (k % CPB == CPB/2) begin
            if (k/CPB == 0)      ok = ok && (serial_out === 1'b0);
            else if (k/CPB <= 8) b[k/CPB-1] = serial_out;
            else                 st = (serial_out === 1'b1);
          end
        end
        if (ok) begin r.d = b; r.stop_ok = st; rx_q.push_back(r); end
      end
    end
  end

  task automatic wait_rx(input int n, input int limit);
    for (int w = 0; w < limit; w++) begin
      if (rx_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; en_g0 = 1'b0; s_valid_g0 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b want 1", serial_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", frame_cnt); end
    n_checks++; if (serial_out_g0 !== 1'b1) begin n_fail++; $display("FAIL reset_serial_g0: got %b want 1", serial_out_g0); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", busy); end
    exp_fc = 0; exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_single();
    int errs;
    rx_t r;
    logic [7:0] e;
    en = 1'b1;
    @(negedge clk); s_valid = 1'b1; s_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk); s_valid = 1'b0;                 // just after E0
    n_checks++; if (fifo_count !== 5'd1 || serial_out !== 1'b1) begin n_fail++; $display("FAIL single_e0: count %0d line %b want 1 1", fifo_count, serial_out); end
    errs = 0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      if (serial_out !== exp_level(8'hA5, k) || busy !== 1'b1) errs++;
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL single_wave: %0d bad cycles want 0", errs); end
    @(negedge clk);
    exp_fc++;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_checks++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL single_frames: got %0d want %0d", frame_cnt, exp_fc); end
    wait_rx(1, 50);
    n_checks++; if (rx_q.size() < 1) begin n_fail++; $display("FAIL single_rx_timeout: got %0d frames want 1", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (r.d !== e || r.stop_ok !== 1'b1) begin n_fail++; $display("FAIL single_byte: got %h stop %b want %h stop 1", r.d, r.stop_ok, e); end
    end
  endtask

  task automatic test_fill();
    rx_t r;
    logic [7:0] e;
    int prev_t, n;
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = i[7:0]; exp_q.push_back(i[7:0]);
    end
    @(negedge clk); s_data = 8'h10; exp_q.push_back(8'h10);
    repeat (4) @(negedge clk);
    n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d want 16", fifo_count); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_no_start: got %b want 0", busy); end
    en = 1'b1;
    @(negedge clk);                                  // after first pop
    n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL fill_first_pop: got %0d want 15", fifo_count); end
    @(negedge clk); s_valid = 1'b0;                  // 0x10 taken here
    n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_late_accept: got %0d want 16", fifo_count); end
    wait_rx(17, 17*FL + 200);
    n_checks++; if (rx_q.size() < 17) begin n_fail++; $display("FAIL fill_rx_timeout: got %0d frames want 17", rx_q.size()); end
    n = 0; prev_t = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (r.d !== e || r.stop_ok !== 1'b1) begin n_fail++; $display("FAIL fill_byte%0d: got %h stop %b want %h stop 1", n, r.d, r.stop_ok, e); end
      if (n > 0) begin
        n_checks++; if (r.t - prev_t != FL) begin n_fail++; $display("FAIL fill_period%0d: got %0d want %0d", n, r.t - prev_t, FL); end
      end
      prev_t = r.t; n++;
    end
    repeat (FL) @(negedge clk);
    exp_fc += 17;
    n_checks++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL fill_frames: got %0d want %0d", frame_cnt, exp_fc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    rx_t r;
    logic [7:0] e;
    int prev_t, n;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = 8'hC0 + i[7:0]; exp_q.push_back(8'hC0 + i[7:0]);
    end
    @(negedge clk); s_valid = 1'b0; en = 1'b1;
    @(negedge clk);                                  // after pop P1
    n_checks++; if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL b2b_count_pre: got %0d want 3", fifo_count); end
    repeat (FL-1) @(negedge clk);
    s_valid = 1'b1; s_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk); s_valid = 1'b0;                  // after pop+push edge
    n_checks++; if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL b2b_count_hold: got %0d want 3", fifo_count); end
    n_checks++; if (serial_out !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: line %b busy %b want 0 1", serial_out, busy); end
    wait_rx(5, 5*FL + 200);
    n_checks++; if (rx_q.size() < 5) begin n_fail++; $display("FAIL b2b_rx_timeout: got %0d frames want 5", rx_q.size()); end
    n = 0; prev_t = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (r.d !== e || r.stop_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_byte%0d: got %h stop %b want %h stop 1", n, r.d, r.stop_ok, e); end
      if (n > 0) begin
        n_checks++; if (r.t - prev_t != FL) begin n_fail++; $display("FAIL b2b_period%0d: got %0d want %0d", n, r.t - prev_t, FL); end
      end
      prev_t = r.t; n++;
    end
    repeat (FL) @(negedge clk);
    exp_fc += 5;
    n_checks++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL b2b_frames: got %0d want %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_en_drop();
    rx_t r;
    logic [7:0] e;
    int t0, n;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = 8'h30 + i[7:0]; exp_q.push_back(8'h30 + i[7:0]);
    end
    @(negedge clk); s_valid = 1'b0; en = 1'b1;
    @(negedge clk); en = 1'b0;                       // inside START bit
    n_checks++; if (busy !== 1'b1 || serial_out !== 1'b0 || fifo_count !== 5'd2) begin n_fail++; $display("FAIL drop_start: busy %b line %b count %0d want 1 0 2", busy, serial_out, fifo_count); end
    repeat (FL+2) @(negedge clk);
    exp_fc++;
    n_checks++; if (busy !== 1'b0 || serial_out !== 1'b1) begin n_fail++; $display("FAIL drop_idle: busy %b line %b want 0 1", busy, serial_out); end
    n_checks++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL drop_frames: got %0d want %0d", frame_cnt, exp_fc); end
    repeat (40) @(negedge clk);
    n_checks++; if (fifo_count !== 5'd2 || rx_q.size() != 1) begin n_fail++; $display("FAIL drop_hold: count %0d frames %0d want 2 1", fifo_count, rx_q.size()); end
    en = 1'b1;
    wait_rx(3, 3*FL + 200);
    n_checks++; if (rx_q.size() < 3) begin n_fail++; $display("FAIL drop_rx_timeout: got %0d frames want 3", rx_q.size()); end
    n = 0; t0 = 0;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (r.d !== e || r.stop_ok !== 1'b1) begin n_fail++; $display("FAIL drop_byte%0d: got %h stop %b want %h stop 1", n, r.d, r.stop_ok, e); end
      if (n == 1) begin
        n_checks++; if (r.t - t0 <= FL + 40) begin n_fail++; $display("FAIL drop_paused: spacing %0d want > %0d", r.t - t0, FL + 40); end
      end
      if (n == 0) t0 = r.t;
      n++;
    end
    repeat (FL) @(negedge clk);
    exp_fc += 2;
    n_checks++; if (frame_cnt !== 16'(exp_fc)) begin n_fail++; $display("FAIL drop_frames_end: got %0d want %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_reset_mid();
    int errs;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = (i == 0) ? 8'h00 : 8'h11 * i[7:0]; exp_q.push_back(s_data);
    end
    @(negedge clk); s_valid = 1'b0; en = 1'b1;
    @(negedge clk);                                  // after pop, 5 queued
    repeat (43) @(negedge clk);                      // offset 43: data bit 4
    n_checks++; if (serial_out !== 1'b0 || fifo_count !== 5'd5) begin n_fail++; $display("FAIL rstmid_pre: line %b count %0d want 0 5", serial_out, fifo_count); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_line: got %b want 1", serial_out); end
    n_checks++; if (fifo_count !== 5'd0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_fifo: count %0d ready %b want 0 1", fifo_count, s_ready); end
    n_checks++; if (frame_cnt !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: frames %0d busy %b want 0 0", frame_cnt, busy); end
    exp_q.delete(); exp_fc = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    errs = 0;
    repeat (120) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) errs++;
    end
    n_checks++; if (errs != 0 || rx_q.size() != 0) begin n_fail++; $display("FAIL rstmid_quiet: bad cycles %0d frames %0d want 0 0", errs, rx_q.size()); end
    n_checks++; if (frame_cnt !== 16'd0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL rstmid_after: frames %0d count %0d want 0 0", frame_cnt, fifo_count); end
  endtask

  task automatic test_gap0();
    int errs;
    logic lv;
    en_g0 = 1'b1;
    @(negedge clk); s_valid_g0 = 1'b1; s_data_g0 = 8'hC3;
    @(negedge clk); s_data_g0 = 8'h3C;               // after E0
    @(negedge clk); s_valid_g0 = 1'b0;               // after E0+1: pop + push
    n_checks++; if (fifo_count_g0 !== 5'd1) begin n_fail++; $display("FAIL gap0_count: got %0d want 1", fifo_count_g0); end
    errs = 0;
    for (int k = 0; k < 180; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 80)       lv = exp_level(8'hC3, k);
      else if (k < 160) lv = exp_level(8'h3C, k - 80);
      else              lv = 1'b1;
      if (serial_out_g0 !== lv) errs++;
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL gap0_wave: %0d bad cycles want 0", errs); end
    n_checks++; if (frame_cnt_g0 !== 16'd2 || busy_g0 !== 1'b0) begin n_fail++; $display("FAIL gap0_end: frames %0d busy %b want 2 0", frame_cnt_g0, busy_g0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_gap0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
